// File: rtl/down_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : down_counter_pkg
// Description : Shared constants for the loadable down counter: default
//               width, default reload value and the RUN/DONE state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package down_counter_pkg;

  // Default counter / reload register width.
  localparam int DC_WIDTH = 4;

  // Value of the count and the reload register after reset (all ones).
  localparam logic [DC_WIDTH-1:0] DC_RELOAD_DEFAULT = 4'hF;

  // Control state encoding.
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

endpackage : down_counter_pkg
`default_nettype wire

// File: rtl/Sub4Bout.sv
`default_nettype none
// ============================================================================
// Module      : Sub4Bout
// Description : WIDTH-bit ripple-borrow decrementer. Produces a_i - 1 and
//               the borrow out of the top bit, which is high exactly when
//               a_i == 0. This is the borrow-chain dual of the carry adder
//               used on the up-counting side: each stage is a LUT computing
//               the difference bit plus a carry cell fed with the inverted
//               operand.
// Ports       : a_i     in  WIDTH  operand (current count)
//               diff_o  out WIDTH  a_i - 1, modulo 2^WIDTH
//               bout_o  out 1      borrow out, 1 when a_i == 0
// Revision    : 1.0 - initial release
// ============================================================================
module Sub4Bout
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DC_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
);

  // borrow[i] is the borrow into bit i. Subtracting the constant 1 is the
  // same as injecting a borrow into bit 0 with a zero subtrahend.
  logic [WIDTH:0] borrow;

  assign borrow[0] = 1'b1;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      // Difference bit: operand xor incoming borrow.
      assign diff_o[i]   = a_i[i] ^ borrow[i];
      // Borrow propagates only through zero bits (carry cell on ~a).
      assign borrow[i+1] = ~a_i[i] & borrow[i];
    end
  endgenerate

  assign bout_o = borrow[WIDTH];

endmodule : Sub4Bout
`default_nettype wire

// File: rtl/down_counter.sv
`default_nettype none
// ============================================================================
// Module      : down_counter
// Description : Loadable down counter with borrow output. Counts from the
//               reload value to zero, then either reloads and pulses wrap
//               (auto-reload) or stops and raises done (one-shot).
// Ports       : CLK          in  1      clock, rising edge
//               RESET        in  1      synchronous active-high reset
//               load         in  1      capture load_value into count+reload
//               load_value   in  WIDTH  value used by load
//               en           in  1      count enable
//               auto_reload  in  1      1 = reload at zero, 0 = one-shot
//               O            out WIDTH  current count (registered)
//               bout         out 1      combinational borrow, O == 0
//               done         out 1      registered, high in DONE
//               wrap         out 1      registered pulse after a reload
// Revision    : 1.0 - initial release
// ============================================================================
module down_counter
  import down_counter_pkg::*;
#(
  parameter int               WIDTH          = DC_WIDTH,
  parameter logic [WIDTH-1:0] RELOAD_DEFAULT = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] O,
  output logic             bout,
  output logic             done,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [0:0]       state_q, state_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] dec_val;
  logic             at_zero;

  // The decrementer's borrow doubles as the zero detect, so bout and the
  // zero-crossing decision share one borrow chain.
  Sub4Bout #(
    .WIDTH (WIDTH)
  ) u_sub (
    .a_i    (count_q),
    .diff_o (dec_val),
    .bout_o (at_zero)
  );

  // Next-state mux. Priority: load over en; RESET is applied in the
  // register block so it overrides everything here.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    state_d  = state_q;
    done_d   = done_q;
    wrap_d   = 1'b0;

    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      state_d  = ST_RUN;
      done_d   = 1'b0;
    end else if (state_q == ST_RUN && en) begin
      if (!at_zero) begin
        count_d = dec_val;
      end else if (auto_reload) begin
        // auto_reload only matters on this zero-crossing edge.
        count_d = reload_q;
        wrap_d  = 1'b1;
      end else begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q  <= RELOAD_DEFAULT;
      reload_q <= RELOAD_DEFAULT;
      state_q  <= ST_RUN;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      state_q  <= state_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
    end
  end

  assign O    = count_q;
  assign bout = at_zero;
  assign done = done_q;
  assign wrap = wrap_q;

endmodule : down_counter
`default_nettype wire

// File: doc/down_counter.md
# down_counter

Loadable down counter with borrow output, the count-down counterpart of the team's 4-bit up counter with carry out (`Counter`). Counts from a reload value to zero, then either reloads (auto-reload mode) or stops and flags completion (one-shot mode). Drives iCE40 timers, delay generators and receive-side bit/word countdowns. `bout` chains into a following stage's `en`, the same way `cout` chains on the up-counting side.

## Interface
Parameters:
- WIDTH, 4, counter and reload register width.
- RELOAD_DEFAULT, 4'hF (all ones at WIDTH), value of `O` and of the reload register after reset.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- load  in  1  capture `load_value` into the counter and the reload register.
- load_value  in  WIDTH  value used by `load`.
- en  in  1  count enable; one decrement per enabled cycle.
- auto_reload  in  1  1 = reload at zero and continue; 0 = one-shot, stop at zero.
- O  out  WIDTH  current count (registered).
- bout  out  1  combinational borrow of O−1, high exactly when O == 0; independent of `en`.
- done  out  1  registered, high while in DONE state.
- wrap  out  1  registered one-cycle pulse on the cycle after a reload-at-zero.

## Operation
- State register: RUN, DONE. Reload register R (WIDTH bits).
- Reset values: O = RELOAD_DEFAULT, R = RELOAD_DEFAULT, state = RUN, done = 0, wrap = 0, bout = (RELOAD_DEFAULT == 0).
- Priority each edge: RESET > load > en.
- load (any state): O ← load_value, R ← load_value, state ← RUN, done ← 0, wrap ← 0.
- RUN, en, O ≠ 0: O ← O − 1 (modulo 2^WIDTH arithmetic; no underflow is possible on this path).
- RUN, en, O == 0, auto_reload = 1: O ← R, wrap ← 1 for one cycle, state stays RUN.
- RUN, en, O == 0, auto_reload = 0: O stays 0, state ← DONE, done ← 1.
- RUN, en = 0: O holds, wrap ← 0.
- DONE: `en` is ignored, O holds 0, done holds 1. Only `load` or `RESET` exits DONE.
- `auto_reload` is sampled only on the zero-crossing edge. Changing it mid-count has no effect until O reaches 0.
- A load of 0 is legal. O = 0 and bout = 1 on the next cycle. The next enabled cycle then reloads 0 (wrap pulses every enabled cycle) or enters DONE.
- Default free-running behaviour with auto_reload = 1 and en = 1 after reset: O counts 15,14,…,0,15,… with bout high at 0. This mirrors the up counter's 0…15 sequence with cout high at 15.

## Timing
- Load-to-output latency: 1 cycle. `O` shows `load_value` on the cycle after `load`.
- From load of N with `en` held high, O reaches 0 after N enabled cycles. Reload or DONE happens on enabled cycle N+1, so the period is N+1.
- bout: zero-cycle combinational path from O. Asserted for the whole cycle O == 0, including while stalled (`en` = 0) and in DONE.
- done: asserts one cycle after the terminating edge and stays high.
- wrap: high for exactly one cycle per reload, the cycle O shows R.
- Simultaneous load and en: load wins, no decrement that cycle.
- RESET mid-count or in DONE: outputs take reset values on the next cycle, regardless of load or en.

## Structure
- Shared package: WIDTH default, RELOAD_DEFAULT, and state encoding constants ST_RUN = 1'b0, ST_DONE = 1'b1.
- Sub-module `Sub4Bout`: WIDTH-bit decrementer producing O−1 and the borrow. It is the ripple-borrow dual of the adder with carry out, built per bit from SB_LUT4 plus SB_CARRY with inverted operand. `bout` is taken from its borrow.
- Top level holds the O/R registers (SB_DFF with synchronous-reset/enable variants), the state bit, and the next-state mux.

## Test plan
- Reset release, auto_reload = 1, en = 1 for 17 cycles → O = 15,14,…,0,15,14. bout high only at O = 0. wrap pulses once, when O returns to 15.
- load 5, auto_reload = 0, en = 1 → O = 5,4,3,2,1,0,0. done rises on the 7th cycle after load and stays high. Further en pulses leave O = 0.
- load 3, then en toggled 1,0,1,0… → O decrements only on enabled cycles and holds value otherwise. bout = 1 while stalled at 0.
- load 0, auto_reload = 1, en = 1 → O stays 0, bout constantly 1, wrap high every cycle after the first.
- Count at O = 2 with load = 1 and load_value = 9 in the same cycle as en → next O = 9, not 1. R = 9, so the next wrap reloads 9.
- In DONE, assert RESET for one cycle together with load = 1 → O = 15, done = 0, R = 15. The load is ignored.
